// File: rtl/l2_port_arbiter_if.sv
// Wishbone-style line bus between one master and one slave.
// The master modport drives the request side; the slave modport returns data and ack.
interface l2_port_arbiter_if #(
  parameter int unsigned ADR_W = 12,
  parameter int unsigned DAT_W = 128,
  parameter int unsigned SEL_W = 16
);

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] dat_m;
  logic [DAT_W-1:0] dat_s;
  logic             ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack
  );

endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 line port between the icache and dcache masters.
// One line transaction at a time; ack/data are routed back only to the granted master.
module l2_port_arbiter #(
  parameter int unsigned ADR_W = 12,
  parameter int unsigned DAT_W = 128,
  parameter int unsigned SEL_W = DAT_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_port_arbiter_if.slave      i,
  l2_port_arbiter_if.slave      d,
  l2_port_arbiter_if.master     l2,
  output logic [15:0]           conflict_count
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_grant;
  logic       last_grant_nxt;
  logic       i_req;
  logic       d_req;

  // The icache is read-only and always fetches whole lines.
  logic unused_icache_wr;
  assign unused_icache_wr = &{1'b0, i.we, i.sel, i.dat_m};

  assign i_req = i.cyc & i.stb;
  assign d_req = d.cyc & d.stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next-state and bus steering; the grant decision lands in state so L2 sees it a cycle later.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    l2.cyc         = 1'b0;
    l2.stb         = 1'b0;
    l2.we          = 1'b0;
    l2.adr         = '0;
    l2.sel         = '0;
    l2.dat_m       = '0;
    i.ack          = 1'b0;
    i.dat_s        = '0;
    d.ack          = 1'b0;
    d.dat_s        = '0;

    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_nxt = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
        end else if (d_req) begin
          state_nxt = SERVE_D;
        end else if (i_req) begin
          state_nxt = SERVE_I;
        end
      end

      SERVE_I: begin
        l2.cyc = 1'b1;
        l2.stb = 1'b1;
        l2.adr = i.adr;
        l2.sel = '1;
        if (l2.ack) begin
          i.ack          = 1'b1;
          i.dat_s        = l2.dat_s;
          last_grant_nxt = GRANT_I;
          state_nxt      = GAP;
        end else if (!i_req) begin
          state_nxt = IDLE;
        end
      end

      SERVE_D: begin
        l2.cyc   = 1'b1;
        l2.stb   = 1'b1;
        l2.we    = d.we;
        l2.adr   = d.adr;
        l2.sel   = d.sel;
        l2.dat_m = d.dat_m;
        if (l2.ack) begin
          d.ack          = 1'b1;
          d.dat_s        = l2.dat_s;
          last_grant_nxt = GRANT_D;
          state_nxt      = GAP;
        end else if (!d_req) begin
          state_nxt = IDLE;
        end
      end

      GAP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Saturating count of cycles in which both masters are requesting.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_count <= '0;
    end else if (i_req && d_req && (conflict_count != '1)) begin
      conflict_count <= conflict_count + CNT_W'(1);
    end
  end

endmodule
